reg_dump_streamer: RTL and testbench

Debug readout engine for the 32×32 register file. On a start request it walks the register file's debug read port through all registers. It serialises each 32-bit value into a byte stream with a valid/ready handshake, for a UART or host-link transmitter. It is the consumer of the debug port: it drives the debug read address and receives the debug data. In this design the register file's debug clock is tied to `clock`.

---
 rtl/reg_dump_pkg.sv | 21 ++
 rtl/word_serializer.sv | 72 +++++++
 rtl/reg_dump_streamer.sv | 128 ++++++++++++
 tb/tb_reg_dump_streamer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file dump streamer.
//   dump_state_e  : sequencing states of the dump FSM
//   DUMP_HEADER   : frame start byte sent before the first register
//   BYTES_PER_REG : bytes emitted per 32-bit register
//   BYTE_IDX_W    : width of the per-word byte index
package reg_dump_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StAddr,
    StCapt,
    StSend,
    StDone
  } dump_state_e;

  localparam logic [7:0]  DUMP_HEADER   = 8'hA5;
  localparam int unsigned BYTES_PER_REG = 4;
  localparam int unsigned BYTE_IDX_W    = 2;

endpackage

// File: rtl/word_serializer.sv
// Loads a word on a load strobe and emits its bytes MSB-first over valid/ready.
// Ports:
//   clock, reset     : clock and synchronous active-high reset
//   load_i           : load word_i and start emitting (takes priority over a transfer)
//   word_i           : word to serialise
//   last_idx_i       : index of the final byte to emit (0 = only the top byte)
//   byte_o, valid_o  : registered stream outputs
//   ready_i          : downstream ready
//   last_accept_o    : strobe, high in the cycle whose closing edge accepts the final byte
module word_serializer
  import reg_dump_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [BYTE_IDX_W-1:0] last_idx_i,
  output logic [7:0]            byte_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_accept_o
);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  valid_q, valid_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [BYTE_IDX_W-1:0] last_q, last_d;
  logic                  accept;

  // The outgoing byte is always the top of the shift register, so byte_o is a flop output.
  assign byte_o        = shift_q[DATA_WIDTH-1 -: 8];
  assign valid_o       = valid_q;
  assign accept        = valid_q & ready_i;
  assign last_accept_o = accept & (idx_q == last_q);

  always_comb begin
    shift_d = shift_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (load_i) begin
      shift_d = word_i;
      valid_d = 1'b1;
      idx_d   = '0;
      last_d  = last_idx_i;
    end else if (accept) begin
      shift_d = shift_q << 8;
      if (idx_q == last_q) begin
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      shift_q <= shift_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/reg_dump_streamer.sv
// Walks the register file debug read port and streams a frame of
// header byte + every register (big-endian) over a valid/ready byte interface.
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   start               : request a full dump (sampled only while idle)
//   read_address_debug  : register file debug read address
//   data_out_debug      : registered debug data, valid one edge after the address
//   byte_out/byte_valid : stream data/valid, byte_ready : downstream ready
//   busy                : dump in progress (through the done cycle)
//   done                : one-cycle pulse after the final byte is accepted
module reg_dump_streamer
  import reg_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] read_address_debug,
  input  logic [DATA_WIDTH-1:0] data_out_debug,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_REGS - 1);

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  ser_load;
  logic [DATA_WIDTH-1:0] ser_word;
  logic [BYTE_IDX_W-1:0] ser_last_idx;
  logic                  last_accept;

  // The counter flop drives the address directly; it is stable across ADDR and CAPT.
  assign read_address_debug = cnt_q;
  assign busy               = busy_q;
  assign done               = done_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ser_load     = 1'b0;
    ser_word     = '0;
    ser_last_idx = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Header goes through the serializer as a one-byte word.
          ser_load                     = 1'b1;
          ser_word[DATA_WIDTH-1 -: 8]  = DUMP_HEADER;
          ser_last_idx                 = '0;
          cnt_d                        = '0;
          busy_d                       = 1'b1;
          state_d                      = StHdr;
        end
      end
      StHdr: begin
        if (last_accept) state_d = StAddr;
      end
      StAddr: begin
        state_d = StCapt;
      end
      StCapt: begin
        ser_load     = 1'b1;
        ser_word     = data_out_debug;
        ser_last_idx = BYTE_IDX_W'(BYTES_PER_REG - 1);
        state_d      = StSend;
      end
      StSend: begin
        if (last_accept) begin
          if (cnt_q == LastAddr) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StAddr;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  word_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_serializer (
    .clock         (clock),
    .reset         (reset),
    .load_i        (ser_load),
    .word_i        (ser_word),
    .last_idx_i    (ser_last_idx),
    .byte_o        (byte_out),
    .valid_o       (byte_valid),
    .ready_i       (byte_ready),
    .last_accept_o (last_accept)
  );

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench for reg_dump_streamer with a behavioural 32x32 register
// file whose debug output is registered (one edge address-to-data).
module tb_reg_dump_streamer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  read_address_debug;
  logic [31:0] data_out_debug;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  logic [7:0]  got_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  always @(posedge clock) data_out_debug <= regs[read_address_debug];

  reg_dump_streamer #(
    .NUM_REGS   (32),
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .read_address_debug (read_address_debug),
    .data_out_debug     (data_out_debug),
    .byte_out           (byte_out),
    .byte_valid         (byte_valid),
    .byte_ready         (byte_ready),
    .busy               (busy),
    .done               (done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a frame (start sampled at edge 0) and runs until done or a cycle bound.
  // Cycle n is the interval between edge n-1 and edge n; outputs are sampled at its negedge.
  task automatic run_frame(input bit rand_ready, input int start_a, input int start_b,
                           input bit hold_start, output int done_cyc, output int stalls);
    bit         prev_stall;
    logic [7:0] prev_byte;
    got_q.delete();
    done_cyc   = -1;
    stalls     = 0;
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    start      = 1'b1;
    @(posedge clock); #1;
    for (int cyc = 1; cyc < 2000 && done_cyc < 0; cyc++) begin
      start      = hold_start || (cyc == start_a) || (cyc == start_b);
      byte_ready = rand_ready ? (($urandom % 3) != 0) : 1'b1;
      @(negedge clock);
      if (prev_stall) begin
        check_val("hold_valid", byte_valid, 1);
        check_val("hold_byte", byte_out, prev_byte);
      end
      if (byte_valid && byte_ready) got_q.push_back(byte_out);
      prev_stall = byte_valid && !byte_ready;
      if (prev_stall) stalls++;
      prev_byte = byte_out;
      if (cyc == 1) begin
        check_val("hdr_valid", byte_valid, 1);
        check_val("hdr_byte", byte_out, 8'hA5);
        check_val("hdr_busy", busy, 1);
      end
      if (!rand_ready && cyc == 8) check_val("addr_reg1", read_address_debug, 1);
      if (!rand_ready && cyc == 188) check_val("addr_reg31", read_address_debug, 31);
      if (done) begin
        done_cyc = cyc;
        check_val("busy_in_done", busy, 1);
      end
      @(posedge clock); #1;
    end
    if (!hold_start) start = 1'b0;
    byte_ready = 1'b1;
    if (done_cyc < 0) check_val("done_timeout", 0, 1);
  endtask

  task automatic check_frame(input string tag);
    logic [7:0]  e;
    logic [31:0] w;
    check_val({tag, "_len"}, got_q.size(), 129);
    for (int i = 0; i < got_q.size() && i < 129; i++) begin
      if (i == 0) begin
        e = 8'hA5;
      end else begin
        w = regs[(i - 1) / 4];
        e = 8'(w >> (24 - 8 * ((i - 1) % 4)));
      end
      check_val($sformatf("%s_b%0d", tag, i), got_q[i], e);
    end
  endtask

  task automatic check_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_val({tag, "_valid"}, byte_valid, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, done, 0);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int dc;
    int st;
    reset      = 1'b1;
    start      = 1'b0;
    byte_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);

    // Reset
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    check_val("rst_addr", read_address_debug, 0);
    check_val("rst_byte", byte_out, 0);
    check_val("rst_valid", byte_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_quiet("idle", 10);

    // Full dump, no backpressure
    run_frame(1'b0, 0, 0, 1'b0, dc, st);
    check_frame("full");
    check_val("full_done_cyc", dc, 194);
    if (got_q.size() == 129) begin
      check_val("full_reg1_lsb", got_q[8], 8'h01);
      check_val("full_reg31_lsb", got_q[128], 8'h1F);
    end
    check_quiet("full_after", 3);

    // Backpressure
    regs[5] = 32'hDEADBEEF;
    run_frame(1'b1, 0, 0, 1'b0, dc, st);
    check_frame("bp");
    check_val("bp_done_cyc", dc, 194 + st);
    check_val("bp_stalls_seen", st > 0, 1);
    if (got_q.size() == 129) begin
      check_val("bp_r5_b0", got_q[21], 8'hDE);
      check_val("bp_r5_b1", got_q[22], 8'hAD);
      check_val("bp_r5_b2", got_q[23], 8'hBE);
      check_val("bp_r5_b3", got_q[24], 8'hEF);
    end
    check_quiet("bp_after", 3);

    // Start pulses while busy are ignored
    run_frame(1'b0, 5, 100, 1'b0, dc, st);
    check_frame("sbusy");
    check_val("sbusy_done_cyc", dc, 194);
    check_quiet("sbusy_after", 10);

    // Start held across DONE: idle in cycle 195, header in cycle 196
    run_frame(1'b0, 0, 0, 1'b1, dc, st);
    check_val("hold_done_cyc", dc, 194);
    @(negedge clock);
    check_val("hold_c195_busy", busy, 0);
    check_val("hold_c195_valid", byte_valid, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check_val("hold_c196_valid", byte_valid, 1);
    check_val("hold_c196_byte", byte_out, 8'hA5);
    check_val("hold_c196_busy", busy, 1);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;

    // Reset during SEND of register 3 (cycles 22..25)
    byte_ready = 1'b1;
    start      = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (22) @(posedge clock);
    #1;
    @(negedge clock);
    check_val("mid_send_valid", byte_valid, 1);
    check_val("mid_send_addr", read_address_debug, 3);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_val("mid_rst_valid", byte_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_addr", read_address_debug, 0);
    @(posedge clock); #1;
    check_quiet("mid_rst_quiet", 5);
    run_frame(1'b0, 0, 0, 1'b0, dc, st);
    check_frame("after_rst");
    check_val("after_rst_done_cyc", dc, 194);
    if (got_q.size() > 0) check_val("after_rst_first", got_q[0], 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
